pwm_ramp_sequencer: RTL and testbench

Duty-cycle sequencer in front of the PWM controller core. It latches a target duty, step size and step interval from the AXI4-Lite register file. It then moves the duty value presented to the PWM core toward the target by one step every `interval+1` PWM periods. Updates land only on PWM period boundaries, so each period runs entirely at one duty value.

---
 rtl/pwm_ramp_sequencer_if.sv | 43 ++++
 rtl/pwm_ramp_sequencer.sv | 113 +++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_sequencer_if.sv
// ---------------------------------------------------------------------------
// pwm_ramp_sequencer_if
// Bundles the configuration strobe, the PWM period handshake and the duty
// outputs of the ramp sequencer.
//
//   enable       sequencer run enable (low freezes the ramp)
//   cfg_load     one-cycle strobe latching target_duty / step / interval
//   target_duty  final duty value
//   step         duty change per update (0 = jump straight to target)
//   interval     extra PWM periods between updates
//   period_end   one-cycle pulse at the last cycle of each PWM period
//   duty_out     registered duty value presented to the PWM core
//   duty_valid   one-cycle pulse when duty_out takes a new value
//   busy         high while ramping
//   done         one-cycle pulse when the target is reached
//
// master: the register file / PWM core side. slave: the sequencer.
// ---------------------------------------------------------------------------
interface pwm_ramp_sequencer_if #(
    parameter int DW = 8,
    parameter int IW = 16
);
    logic          enable;
    logic          cfg_load;
    logic [DW-1:0] target_duty;
    logic [DW-1:0] step;
    logic [IW-1:0] interval;
    logic          period_end;
    logic [DW-1:0] duty_out;
    logic          duty_valid;
    logic          busy;
    logic          done;

    modport master (
        output enable, cfg_load, target_duty, step, interval, period_end,
        input  duty_out, duty_valid, busy, done
    );

    modport slave (
        input  enable, cfg_load, target_duty, step, interval, period_end,
        output duty_out, duty_valid, busy, done
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_ramp_sequencer
// Moves the duty value presented to the PWM core toward a latched target,
// one step every interval+1 PWM periods. Updates are applied only on PWM
// period boundaries so every period runs at a single duty value.
//
//   clock   system clock, rising edge
//   reset   synchronous active-high reset
//   bus     pwm_ramp_sequencer_if.slave (config, period handshake, outputs)
// ---------------------------------------------------------------------------
module pwm_ramp_sequencer #(
    parameter int DW = 8,
    parameter int IW = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    pwm_ramp_sequencer_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] target_q;
    logic [DW-1:0] step_q;
    logic [IW-1:0] interval_q;
    logic [IW-1:0] count_q;
    logic [DW-1:0] duty_q;
    logic          duty_valid_q;
    logic          done_q;

    logic [DW:0]          sum_up;
    logic signed [DW+1:0] diff_down;
    logic [DW-1:0]        next_duty;
    logic                 boundary;

    // Next duty value for an update. The up-sum carries one extra bit so it
    // cannot wrap past the top of the range, and the down-difference is
    // signed with headroom so it cannot underflow below zero; either way
    // the result is clamped to the target. Zero step (or an already-equal
    // duty) falls through to the target itself.
    always_comb begin
        sum_up    = {1'b0, duty_q} + {1'b0, step_q};
        diff_down = $signed({2'b00, duty_q}) - $signed({2'b00, step_q});
        next_duty = target_q;
        if (step_q != '0) begin
            if (target_q > duty_q) begin
                if (sum_up < {1'b0, target_q})
                    next_duty = sum_up[DW-1:0];
            end else if (target_q < duty_q) begin
                if (diff_down > $signed({2'b00, target_q}))
                    next_duty = diff_down[DW-1:0];
            end
        end
    end

    // A period boundary only counts while ramping, enabled, and not
    // colliding with a configuration load (the load takes priority and
    // restarts the interval count).
    assign boundary = (state == RAMP) && bus.enable && bus.period_end && !bus.cfg_load;

    // Sequencer FSM. cfg_load is honoured in any state regardless of
    // enable; loading a target equal to the current duty finishes at once
    // with a done pulse but no duty_valid. Otherwise each (interval+1)-th
    // qualifying boundary applies one step.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            target_q     <= '0;
            step_q       <= '0;
            interval_q   <= '0;
            count_q      <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            duty_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (bus.cfg_load) begin
                target_q   <= bus.target_duty;
                step_q     <= bus.step;
                interval_q <= bus.interval;
                count_q    <= '0;
                if (bus.target_duty != duty_q) begin
                    state <= RAMP;
                end else begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end
            end else if (boundary) begin
                if (count_q != interval_q) begin
                    count_q <= count_q + 1'b1;
                end else begin
                    count_q      <= '0;
                    duty_q       <= next_duty;
                    duty_valid_q <= 1'b1;
                    if (next_duty == target_q) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
            end
        end
    end

    assign bus.duty_out   = duty_q;
    assign bus.duty_valid = duty_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state == RAMP);

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_ramp_sequencer
// Self-checking bench for pwm_ramp_sequencer. Scenario tasks push the
// expected duty_valid/done events into a queue as they drive stimulus; a
// monitor pops and compares whenever the DUT reports an event.
// ---------------------------------------------------------------------------
module tb_pwm_ramp_sequencer;

    typedef struct {
        logic [7:0] duty;
        logic       valid;
        logic       done;
    } ev_t;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    ev_t  sb[$];

    pwm_ramp_sequencer_if #(.DW(8), .IW(16)) bus ();

    pwm_ramp_sequencer #(.DW(8), .IW(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Event monitor: sample 1 unit after each rising edge and compare every
    // reported duty_valid/done event against the scoreboard head.
    always begin
        @(posedge clock);
        #1;
        if (!reset && (bus.duty_valid || bus.done)) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_event: duty_out=%0d duty_valid=%0b done=%0b, required no event",
                         bus.duty_out, bus.duty_valid, bus.done);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (bus.duty_out !== e.duty || bus.duty_valid !== e.valid || bus.done !== e.done) begin
                    miscompares++;
                    $display("[TB] FAIL event: duty_out=%0d duty_valid=%0b done=%0b, required duty_out=%0d duty_valid=%0b done=%0b",
                             bus.duty_out, bus.duty_valid, bus.done, e.duty, e.valid, e.done);
                end
            end
        end
    end

    // Push one expected event.
    task automatic expect_ev(input logic [7:0] duty, input logic valid, input logic done);
        ev_t e;
        e.duty  = duty;
        e.valid = valid;
        e.done  = done;
        sb.push_back(e);
    endtask

    // Wait (bounded) for all expected events to have been seen.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_drain: %0d events outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Single-cycle configuration load.
    task automatic load(input logic [7:0] tgt, input logic [7:0] stp, input logic [15:0] intv);
        @(negedge clock);
        bus.cfg_load    = 1'b1;
        bus.target_duty = tgt;
        bus.step        = stp;
        bus.interval    = intv;
        @(negedge clock);
        bus.cfg_load    = 1'b0;
    endtask

    // n PWM period boundaries, each followed by a quiet cycle.
    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.period_end = 1'b1;
            @(negedge clock);
            bus.period_end = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic check_state(input string name, input logic [7:0] duty, input logic busy);
        vectors++;
        if (bus.duty_out !== duty || bus.busy !== busy) begin
            miscompares++;
            $display("[TB] FAIL %s: duty_out=%0d busy=%0b, required duty_out=%0d busy=%0b",
                     name, bus.duty_out, bus.busy, duty, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.enable      = 1'($urandom_range(0, 1));
            bus.cfg_load    = 1'($urandom_range(0, 1));
            bus.target_duty = 8'($urandom_range(1, 255));
            bus.step        = 8'($urandom_range(0, 255));
            bus.interval    = 16'($urandom_range(0, 3));
            bus.period_end  = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        vectors++;
        if (bus.duty_out !== 8'd0 || bus.busy !== 1'b0 || bus.duty_valid !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset: duty_out=%0d busy=%0b duty_valid=%0b done=%0b, required all 0",
                     bus.duty_out, bus.busy, bus.duty_valid, bus.done);
        end
        bus.enable     = 1'b1;
        bus.cfg_load   = 1'b0;
        bus.period_end = 1'b0;
        reset          = 1'b0;
        @(negedge clock);
        check_state("post_reset", 8'd0, 1'b0);
    endtask

    task automatic test_up_ramp();
        expect_ev(8'd3, 1'b1, 1'b0);
        expect_ev(8'd6, 1'b1, 1'b0);
        expect_ev(8'd9, 1'b1, 1'b0);
        expect_ev(8'd10, 1'b1, 1'b1);
        load(8'd10, 8'd3, 16'd0);
        check_state("up_busy", 8'd0, 1'b1);
        pulse(4);
        drain("up");
        check_state("up_end", 8'd10, 1'b0);
    endtask

    task automatic test_down_interval();
        load(8'd0, 8'd4, 16'd2);
        pulse(2);
        check_state("down_hold", 8'd10, 1'b1);
        expect_ev(8'd6, 1'b1, 1'b0);
        pulse(3);
        expect_ev(8'd2, 1'b1, 1'b0);
        pulse(3);
        expect_ev(8'd0, 1'b1, 1'b1);
        pulse(1);
        drain("down");
        check_state("down_end", 8'd0, 1'b0);
    endtask

    task automatic test_saturation();
        expect_ev(8'd250, 1'b1, 1'b1);
        load(8'd250, 8'd0, 16'd0);
        pulse(1);
        expect_ev(8'd255, 1'b1, 1'b1);
        load(8'd255, 8'd200, 16'd0);
        pulse(1);
        drain("sat_up");
        check_state("sat_up_end", 8'd255, 1'b0);
        expect_ev(8'd5, 1'b1, 1'b1);
        load(8'd5, 8'd0, 16'd0);
        pulse(1);
        expect_ev(8'd0, 1'b1, 1'b1);
        load(8'd0, 8'd200, 16'd0);
        pulse(1);
        drain("sat_down");
        check_state("sat_down_end", 8'd0, 1'b0);
        expect_ev(8'd77, 1'b1, 1'b1);
        load(8'd77, 8'd0, 16'd0);
        pulse(1);
        drain("jump");
        check_state("jump_end", 8'd77, 1'b0);
    endtask

    task automatic test_freeze_retarget();
        expect_ev(8'd87, 1'b1, 1'b0);
        load(8'd200, 8'd10, 16'd1);
        pulse(2);
        drain("freeze_pre");
        check_state("freeze_pre", 8'd87, 1'b1);
        bus.enable = 1'b0;
        pulse(3);
        check_state("frozen", 8'd87, 1'b1);
        bus.enable = 1'b1;
        pulse(1);
        check_state("counting", 8'd87, 1'b1);
        // Counter now equals interval: a counted boundary here would update.
        @(negedge clock);
        bus.cfg_load    = 1'b1;
        bus.period_end  = 1'b1;
        bus.target_duty = 8'd0;
        bus.step        = 8'd10;
        bus.interval    = 16'd1;
        @(negedge clock);
        bus.cfg_load    = 1'b0;
        bus.period_end  = 1'b0;
        @(negedge clock);
        check_state("retarget_collide", 8'd87, 1'b1);
        pulse(1);
        check_state("retarget_restart", 8'd87, 1'b1);
        expect_ev(8'd77, 1'b1, 1'b0);
        pulse(1);
        drain("reverse");
        check_state("reverse", 8'd77, 1'b1);
    endtask

    task automatic test_reset_mid_ramp();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_state("mid_reset", 8'd0, 1'b0);
        pulse(2);
        check_state("idle_ignore", 8'd0, 1'b0);
        expect_ev(8'd0, 1'b0, 1'b1);
        load(8'd0, 8'd5, 16'd3);
        check_state("equal_load", 8'd0, 1'b0);
        drain("equal_load");
        pulse(1);
        check_state("equal_after", 8'd0, 1'b0);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.target_duty = '0;
        bus.step        = '0;
        bus.interval    = '0;
        bus.period_end  = 1'b0;
        test_reset();
        test_up_ramp();
        test_down_interval();
        test_saturation();
        test_freeze_retarget();
        test_reset_mid_ramp();
        repeat (4) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
